// File: rtl/alu_pkg.sv
// alu_pkg -- shared constants for the ALU issue controller.
// Holds ALU control codes, LEGv8 opcode constants and the FSM state enum.
// Optional feature macro used by the including files: ALU_ISSUE_CBZ_EN.
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_OR    = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_PASSB = 4'b0111;
  localparam logic [3:0] CTRL_NONE  = 4'b1111;

  // LEGv8 opcode field values (instr[31:21])
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ only fixes the top 8 bits; the low 3 bits belong to the immediate
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_cbz_op(input logic [10:0] op);
    return op[10:3] == OP_CBZ_HI;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode -- combinational LEGv8 opcode decode into ALU control.
// CBZ is recognised only when ALU_ISSUE_CBZ_EN is defined; otherwise it
// falls through to the illegal-opcode path.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [10:0] i_opcode,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_illegal,
  output logic        o_is_cbz
);

  // Map the opcode to an ALU control code, flagging anything unrecognised
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_alu_ctrl = CTRL_NONE;
    o_illegal  = 1'b1;
    o_is_cbz   = 1'b0;
    case (i_opcode)
      OP_ADD, OP_LDUR, OP_STUR: begin
        o_alu_ctrl = CTRL_ADD;
        o_illegal  = 1'b0;
      end
      OP_SUB: begin
        o_alu_ctrl = CTRL_SUB;
        o_illegal  = 1'b0;
      end
      OP_AND: begin
        o_alu_ctrl = CTRL_AND;
        o_illegal  = 1'b0;
      end
      OP_ORR: begin
        o_alu_ctrl = CTRL_OR;
        o_illegal  = 1'b0;
      end
      default: begin
`ifdef ALU_ISSUE_CBZ_EN
        if (is_cbz_op(i_opcode)) begin
          o_alu_ctrl = CTRL_PASSB;
          o_illegal  = 1'b0;
          o_is_cbz   = 1'b1;
        end
`endif
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl -- single-outstanding issue controller in front of an
// external LEGv8 ALU. IDLE accepts a request, EXEC drives the ALU buses and
// captures the result, RESP holds the response until it is consumed.
// Optional feature: ALU_ISSUE_CBZ_EN enables CBZ branch resolution
// (BranchTaken); when undefined CBZ is illegal and BranchTaken is tied 0.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              InValid,
  output logic              InReady,
  input  logic [10:0]       Opcode,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  output logic [3:0]        ALUCtrl,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  input  logic [DATA_W-1:0] BusW,
  input  logic              Zero,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Result,
  output logic              ZeroOut,
  output logic              IllegalOp,
  output logic              BranchTaken
);

  state_e              r_state;
  state_e              w_next_state;
  logic                w_accept;
  logic [10:0]         r_opcode;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [3:0]          w_dec_ctrl;
  logic                w_dec_illegal;
  logic                w_dec_is_cbz;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic                r_illegal;
  logic                r_branch_taken;

  // Accept only in IDLE; InReady itself is decoded from state alone
  assign w_accept = (r_state == ST_IDLE) && InValid;

  // Decode the registered opcode so ALU controls come from stored state only
  alu_op_decode u_decode (
    .i_opcode   (r_opcode),
    .o_alu_ctrl (w_dec_ctrl),
    .o_illegal  (w_dec_illegal),
    .o_is_cbz   (w_dec_is_cbz)
  );

  // State register
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment to avoid update-order races.
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (InValid) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (OutReady) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and registered request only
  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    ALUCtrl  = CTRL_NONE;
    BusA     = '0;
    BusB     = '0;
    case (r_state)
      ST_IDLE: InReady = 1'b1;
      ST_EXEC: begin
        ALUCtrl = w_dec_ctrl;
        BusA    = r_opa;
        BusB    = r_opb;
      end
      ST_RESP: OutValid = 1'b1;
      default: InReady = 1'b0;
    endcase
  end

  // Request capture on the accept edge
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      // NOTE: datapath registers are reset as well, since response fields must read 0 out of reset.
      r_opcode <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
    end else if (w_accept) begin
      r_opcode <= Opcode;
      r_opa    <= OpA;
      r_opb    <= OpB;
    end
  end

  // Response capture at the end of EXEC; held through RESP until the next EXEC
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_result       <= '0;
      r_zero         <= 1'b0;
      r_illegal      <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      // An undecoded opcode returns 0 whatever the ALU produced
      r_result  <= w_dec_illegal ? '0 : BusW;
      r_zero    <= Zero;
      r_illegal <= w_dec_illegal;
`ifdef ALU_ISSUE_CBZ_EN
      r_branch_taken <= w_dec_is_cbz && Zero;
`else
      r_branch_taken <= 1'b0;
`endif
    end
  end

`ifndef ALU_ISSUE_CBZ_EN
  // CBZ is never decoded in this build, so the flag has no consumer
  logic w_unused_is_cbz;
  assign w_unused_is_cbz = w_dec_is_cbz;
`endif

  assign Result      = r_result;
  assign ZeroOut     = r_zero;
  assign IllegalOp   = r_illegal;
  assign BranchTaken = r_branch_taken;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl -- self-checking bench for alu_issue_ctrl.
// Provides a behavioural ALU on BusA/BusB/ALUCtrl and compares every
// response against an opcode-level reference model.
module tb_alu_issue_ctrl;

  localparam int DW = 64;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_CBZ  = 11'b10110100000;

`ifdef ALU_ISSUE_CBZ_EN
  localparam bit CBZ_EN = 1'b1;
`else
  localparam bit CBZ_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          Reset_L;
  logic          InValid;
  logic          InReady;
  logic [10:0]   Opcode;
  logic [DW-1:0] OpA, OpB;
  logic [3:0]    ALUCtrl;
  logic [DW-1:0] BusA, BusB, BusW;
  logic          Zero;
  logic          OutValid;
  logic          OutReady;
  logic [DW-1:0] Result;
  logic          ZeroOut, IllegalOp, BranchTaken;

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(.DATA_W(DW)) dut (
    .CLK         (CLK),
    .Reset_L     (Reset_L),
    .InValid     (InValid),
    .InReady     (InReady),
    .Opcode      (Opcode),
    .OpA         (OpA),
    .OpB         (OpB),
    .ALUCtrl     (ALUCtrl),
    .BusA        (BusA),
    .BusB        (BusB),
    .BusW        (BusW),
    .Zero        (Zero),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Result      (Result),
    .ZeroOut     (ZeroOut),
    .IllegalOp   (IllegalOp),
    .BranchTaken (BranchTaken)
  );

  always #5 CLK = ~CLK;

  // External ALU; an unknown control code yields a non-zero junk value
  always_comb begin
    case (ALUCtrl)
      4'b0000: BusW = BusA & BusB;
      4'b0001: BusW = BusA | BusB;
      4'b0010: BusW = BusA + BusB;
      4'b0110: BusW = BusA - BusB;
      4'b0111: BusW = BusB;
      default: BusW = 64'hDEAD_BEEF_0BAD_F00D;
    endcase
    Zero = (BusW == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          illegal;
    logic [3:0]    ctrl;
    logic [DW-1:0] result;
    logic          zero;
    logic          branch;
  } exp_t;

  // Reference: what a request of this opcode and operands should return
  function automatic exp_t ref_model(input logic [10:0] op, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
    exp_t e;
    logic cbz;
    cbz       = CBZ_EN && (op[10:3] == 8'b10110100);
    e.illegal = 1'b0;
    if (op == T_ADD || op == T_LDUR || op == T_STUR) begin
      e.ctrl = 4'b0010; e.result = a + b;
    end else if (op == T_SUB) begin
      e.ctrl = 4'b0110; e.result = a - b;
    end else if (op == T_AND) begin
      e.ctrl = 4'b0000; e.result = a & b;
    end else if (op == T_ORR) begin
      e.ctrl = 4'b0001; e.result = a | b;
    end else if (cbz) begin
      e.ctrl = 4'b0111; e.result = b;
    end else begin
      e.illegal = 1'b1; e.ctrl = 4'b1111; e.result = '0;
    end
    // Illegal ops see the ALU's junk output, which is non-zero
    e.zero   = e.illegal ? 1'b0 : (e.result == '0);
    e.branch = cbz && e.zero;
    return e;
  endfunction

  // One full transaction; starts and ends at a negedge with the DUT idle
  task automatic issue(input logic [10:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input int stall);
    exp_t e;
    e = ref_model(op, a, b);
    InValid  = 1'b1;
    Opcode   = op;
    OpA      = a;
    OpB      = b;
    OutReady = (stall == 0);
    check("idle_in_ready", InReady, 1);
    @(negedge CLK);
    // EXEC: scramble inputs to show only the registered request matters
    InValid = 1'($urandom_range(0, 1));
    Opcode  = 11'($urandom);
    OpA     = {$urandom, $urandom};
    OpB     = {$urandom, $urandom};
    check("exec_in_ready", InReady, 0);
    check("exec_out_valid", OutValid, 0);
    check("exec_aluctrl", ALUCtrl, e.ctrl);
    check("exec_bus_a", BusA, a);
    check("exec_bus_b", BusB, b);
    @(negedge CLK);
    check("resp_out_valid", OutValid, 1);
    check("resp_in_ready", InReady, 0);
    check("resp_result", Result, e.result);
    check("resp_zero_out", ZeroOut, e.zero);
    check("resp_illegal", IllegalOp, e.illegal);
    check("resp_branch", BranchTaken, e.branch);
    check("resp_aluctrl", ALUCtrl, 4'hF);
    for (int i = 1; i <= stall; i++) begin
      InValid = 1'b1;
      Opcode  = T_ADD;
      @(negedge CLK);
      check("hold_out_valid", OutValid, 1);
      check("hold_in_ready", InReady, 0);
      check("hold_result", Result, e.result);
      check("hold_illegal", IllegalOp, e.illegal);
      if (i == stall) OutReady = 1'b1;
    end
    @(negedge CLK);
    InValid = 1'b0;
    check("post_out_valid", OutValid, 0);
    check("post_in_ready", InReady, 1);
    check("idle_aluctrl", ALUCtrl, 4'hF);
    check("idle_bus_a", BusA, 0);
    check("idle_bus_b", BusB, 0);
  endtask

  initial begin
    logic [10:0] ops [8];
    logic [10:0] op;
    logic [DW-1:0] a, b;
    ops[0] = T_ADD; ops[1] = T_SUB; ops[2] = T_AND; ops[3] = T_ORR;
    ops[4] = T_LDUR; ops[5] = T_STUR; ops[6] = T_CBZ; ops[7] = 11'b0;

    Reset_L  = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    Opcode   = '0;
    OpA      = '0;
    OpB      = '0;
    repeat (2) @(negedge CLK);
    check("rst_out_valid", OutValid, 0);
    check("rst_result", Result, 0);
    check("rst_zero_out", ZeroOut, 0);
    check("rst_illegal", IllegalOp, 0);
    check("rst_branch", BranchTaken, 0);
    check("rst_aluctrl", ALUCtrl, 4'hF);
    check("rst_bus_a", BusA, 0);
    check("rst_bus_b", BusB, 0);
    Reset_L = 1'b1;
    @(negedge CLK);
    check("rel_in_ready", InReady, 1);

    // Directed cases
    issue(T_ADD, 64'd5, 64'd7, 0);
    issue(T_SUB, 64'd9, 64'd9, 0);
    issue(T_CBZ, 64'd4, 64'd0, 0);
    issue(T_CBZ | 11'd5, 64'd4, 64'd3, 1);
    issue(11'b0, 64'd1, 64'd2, 0);
    issue(T_ORR, 64'hF0, 64'h0F, 10);

    // Reset pulse while an AND is in EXEC
    InValid = 1'b1;
    Opcode  = T_AND;
    OpA     = 64'hFF;
    OpB     = 64'h0F;
    @(negedge CLK);
    InValid = 1'b0;
    check("and_exec_aluctrl", ALUCtrl, 4'b0000);
    Reset_L = 1'b0;
    #1;
    check("mid_rst_aluctrl", ALUCtrl, 4'hF);
    check("mid_rst_out_valid", OutValid, 0);
    #2;
    Reset_L = 1'b1;
    @(negedge CLK);
    check("after_rst_in_ready", InReady, 1);
    check("after_rst_out_valid", OutValid, 0);
    @(negedge CLK);
    check("after_rst_out_valid2", OutValid, 0);
    check("after_rst_result", Result, 0);
    issue(T_ADD, 64'd1, 64'd1, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == T_CBZ) op = op | 11'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) op = 11'($urandom);
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = '0;
        default: b = {$urandom, $urandom};
      endcase
      issue(op, a, b, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
